// File: rtl/slow_to_fast_capture.sv
// Receive-side capture of a bus launched on slow_clk rising edges, running only on fast_clk.
// slow_clk is sampled as data; each detected edge triggers a settle-then-capture sequence.
module slow_to_fast_capture #(
    parameter int S           = 12,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 1
) (
    input  logic         fast_clk,
    input  logic         reset,
    input  logic         slow_clk,
    input  logic [S-1:0] async_data,
    output logic [S-1:0] sync_data,
    output logic         data_valid,
    output logic         overrun,
    output logic [7:0]   capture_count
);

    localparam int             CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] slow_p;
    logic [SYNC_STAGES-1:0] vld_p;
    logic                   slow_sync, sync_vld, slow_prev, armed, rise;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [S-1:0]           shadow, shadow_n, sync_data_n;
    logic                   data_valid_n, overrun_n;
    logic [7:0]             capture_count_n;

    // Synchronizer stage: vld_p marks when slow_sync holds a real sample rather than the reset zero
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            slow_p    <= '0;
            vld_p     <= '0;
            slow_prev <= 1'b0;
            armed     <= 1'b0;
        end else begin
            slow_p    <= {slow_p[SYNC_STAGES-2:0], slow_clk};
            vld_p     <= {vld_p[SYNC_STAGES-2:0], 1'b1};
            slow_prev <= slow_sync;
            armed     <= armed | (sync_vld & ~slow_sync);
        end
    end

    assign slow_sync = slow_p[SYNC_STAGES-1];
    assign sync_vld  = vld_p[SYNC_STAGES-1];
    assign rise      = slow_sync & ~slow_prev & armed;

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        shadow_n        = shadow;
        sync_data_n     = sync_data;
        data_valid_n    = 1'b0;
        overrun_n       = 1'b0;
        capture_count_n = capture_count;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n  = SETTLE;
                    cnt_n    = CNT_LOAD;
                    shadow_n = async_data;
                end
            end
            SETTLE: begin
                if (rise) begin
                    overrun_n = 1'b1;
                    cnt_n     = CNT_LOAD;
                    shadow_n  = async_data;
                end else if (async_data != shadow) begin
                    cnt_n    = CNT_LOAD;
                    shadow_n = async_data;
                end else if (cnt == CNT_ONE) begin
                    sync_data_n     = shadow;
                    data_valid_n    = 1'b1;
                    capture_count_n = capture_count + 8'd1;
                    state_n         = IDLE;
                end else begin
                    cnt_n = cnt - CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Capture stage
    always_ff @(posedge fast_clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            shadow        <= '0;
            sync_data     <= '0;
            data_valid    <= 1'b0;
            overrun       <= 1'b0;
            capture_count <= 8'd0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            shadow        <= shadow_n;
            sync_data     <= sync_data_n;
            data_valid    <= data_valid_n;
            overrun       <= overrun_n;
            capture_count <= capture_count_n;
        end
    end

endmodule

// File: tb/tb_slow_to_fast_capture.sv
// Directed bench for slow_to_fast_capture: three instances cover SETTLE_CYC of 1, 3 and 4.
// Inputs change and outputs are sampled on the falling edge of the fast clock.
module tb_slow_to_fast_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, slow1, dv1, ov1;
    logic [11:0] data1, sd1;
    logic [7:0]  cc1;
    logic        rst3, slow3, dv3, ov3;
    logic [11:0] data3, sd3;
    logic [7:0]  cc3;
    logic        rst4, slow4, dv4, ov4;
    logic [11:0] data4, sd4;
    logic [7:0]  cc4;

    int checks = 0;
    int passes = 0;

    slow_to_fast_capture dut1 (
        .fast_clk(clk), .reset(rst1), .slow_clk(slow1), .async_data(data1),
        .sync_data(sd1), .data_valid(dv1), .overrun(ov1), .capture_count(cc1)
    );

    slow_to_fast_capture #(.S(12), .SYNC_STAGES(2), .SETTLE_CYC(3)) dut3 (
        .fast_clk(clk), .reset(rst3), .slow_clk(slow3), .async_data(data3),
        .sync_data(sd3), .data_valid(dv3), .overrun(ov3), .capture_count(cc3)
    );

    slow_to_fast_capture #(.S(12), .SYNC_STAGES(2), .SETTLE_CYC(4)) dut4 (
        .fast_clk(clk), .reset(rst4), .slow_clk(slow4), .async_data(data4),
        .sync_data(sd4), .data_valid(dv4), .overrun(ov4), .capture_count(cc4)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
        slow1 = 1'b0; slow3 = 1'b0; slow4 = 1'b0;
        data1 = '0; data3 = '0; data4 = '0;
        tick(3);
        checks++;
        if ({sd1, dv1, ov1, cc1} !== 22'd0) $display("FAIL reset_dut1: got sd=%h dv=%b ov=%b cc=%0d expected all zero", sd1, dv1, ov1, cc1);
        else passes++;
        checks++;
        if ({sd4, dv4, ov4, cc4} !== 22'd0) $display("FAIL reset_dut4: got sd=%h dv=%b ov=%b cc=%0d expected all zero", sd4, dv4, ov4, cc4);
        else passes++;
        rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
        tick(6);
    endtask

    task automatic test_basic();
        int dv_cnt = 0;
        data1 = 12'hA5C;
        slow1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (dv1) dv_cnt++;
            if (k == 3) begin
                checks++;
                if (dv1 !== 1'b0) $display("FAIL basic_early: got dv=%b expected 0", dv1);
                else passes++;
            end
            if (k == 4) begin
                checks++;
                if (dv1 !== 1'b1 || sd1 !== 12'hA5C || cc1 !== 8'd1)
                    $display("FAIL basic_capture: got dv=%b sd=%h cc=%0d expected 1 a5c 1", dv1, sd1, cc1);
                else passes++;
            end
        end
        slow1 = 1'b0;
        checks++;
        if (dv_cnt !== 1) $display("FAIL basic_pulses: got %0d expected 1", dv_cnt);
        else passes++;
        tick(10);
    endtask

    task automatic test_high_at_reset();
        int dv_cnt = 0;
        rst1 = 1'b1;
        slow1 = 1'b1;
        tick(2);
        rst1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (dv1) dv_cnt++;
        end
        checks++;
        if (dv_cnt !== 0 || cc1 !== 8'd0) $display("FAIL high_at_reset_false_edge: got pulses=%0d cc=%0d expected 0 0", dv_cnt, cc1);
        else passes++;
        slow1 = 1'b0;
        tick(4);
        data1 = 12'h7E1;
        slow1 = 1'b1;
        tick(4);
        checks++;
        if (dv1 !== 1'b1 || sd1 !== 12'h7E1 || cc1 !== 8'd1)
            $display("FAIL high_at_reset_capture: got dv=%b sd=%h cc=%0d expected 1 7e1 1", dv1, sd1, cc1);
        else passes++;
        tick(2);
        slow1 = 1'b0;
        tick(6);
    endtask

    task automatic test_data_change();
        int dv_cnt = 0;
        bit saw_old = 1'b0;
        data1 = 12'h123;
        slow1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (dv1) dv_cnt++;
            if (dv1 && sd1 == 12'h123) saw_old = 1'b1;
            if (k == 4) begin
                checks++;
                if (dv1 !== 1'b0) $display("FAIL change_not_extended: got dv=%b expected 0", dv1);
                else passes++;
            end
            if (k == 5) begin
                checks++;
                if (dv1 !== 1'b1 || sd1 !== 12'h456 || cc1 !== 8'd2)
                    $display("FAIL change_capture: got dv=%b sd=%h cc=%0d expected 1 456 2", dv1, sd1, cc1);
                else passes++;
            end
            if (k == 3) data1 = 12'h456;
        end
        slow1 = 1'b0;
        checks++;
        if (dv_cnt !== 1 || saw_old) $display("FAIL change_single: got pulses=%0d old_seen=%b expected 1 0", dv_cnt, saw_old);
        else passes++;
        tick(6);
    endtask

    task automatic test_settle_toggle();
        int dv_cnt = 0;
        data3 = 12'h000;
        slow3 = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            if (dv3) dv_cnt++;
            if (k == 10) begin
                checks++;
                if (dv3 !== 1'b0) $display("FAIL toggle_early: got dv=%b expected 0", dv3);
                else passes++;
            end
            if (k == 11) begin
                checks++;
                if (dv3 !== 1'b1 || sd3 !== 12'hFFF || cc3 !== 8'd1)
                    $display("FAIL toggle_capture: got dv=%b sd=%h cc=%0d expected 1 fff 1", dv3, sd3, cc3);
                else passes++;
            end
            if (k <= 6) data3 = (k % 2 == 1) ? 12'h555 : 12'hAAA;
            else if (k == 7) data3 = 12'hFFF;
        end
        slow3 = 1'b0;
        checks++;
        if (dv_cnt !== 1) $display("FAIL toggle_pulses: got %0d expected 1", dv_cnt);
        else passes++;
        tick(6);
    endtask

    task automatic test_back_to_back();
        logic [11:0] r;
        logic [7:0]  exp_cc;
        rst1 = 1'b1;
        tick(2);
        rst1 = 1'b0;
        tick(5);
        for (int i = 0; i < 256; i++) begin
            r = 12'($urandom);
            exp_cc = 8'(i + 1);
            data1 = r;
            slow1 = 1'b1;
            tick(4);
            checks++;
            if (dv1 !== 1'b1 || sd1 !== r)
                $display("FAIL b2b_word_%0d: got dv=%b sd=%h expected 1 %h", i, dv1, sd1, r);
            else passes++;
            checks++;
            if (cc1 !== exp_cc) $display("FAIL b2b_count_%0d: got %0d expected %0d", i, cc1, exp_cc);
            else passes++;
            tick(2);
            slow1 = 1'b0;
            tick(4);
        end
        checks++;
        if (cc1 !== 8'd0) $display("FAIL b2b_wrap: got %0d expected 0", cc1);
        else passes++;
    endtask

    task automatic test_overrun();
        int ov_cnt = 0;
        int dv_cnt = 0;
        bit saw_old = 1'b0;
        data4 = 12'h111;
        slow4 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (ov4) ov_cnt++;
            if (dv4) dv_cnt++;
            if (dv4 && sd4 == 12'h111) saw_old = 1'b1;
            if (k == 6 || k == 8) begin
                checks++;
                if (ov4 !== 1'b0) $display("FAIL overrun_quiet_k%0d: got %b expected 0", k, ov4);
                else passes++;
            end
            if (k == 7) begin
                checks++;
                if (ov4 !== 1'b1) $display("FAIL overrun_pulse: got %b expected 1", ov4);
                else passes++;
            end
            if (k == 11) begin
                checks++;
                if (dv4 !== 1'b1 || sd4 !== 12'h222 || cc4 !== 8'd1)
                    $display("FAIL overrun_capture: got dv=%b sd=%h cc=%0d expected 1 222 1", dv4, sd4, cc4);
                else passes++;
            end
            if (k == 2) slow4 = 1'b0;
            if (k == 4) begin
                slow4 = 1'b1;
                data4 = 12'h222;
            end
        end
        slow4 = 1'b0;
        checks++;
        if (ov_cnt !== 1 || dv_cnt !== 1 || saw_old)
            $display("FAIL overrun_counts: got ov=%0d dv=%0d old_seen=%b expected 1 1 0", ov_cnt, dv_cnt, saw_old);
        else passes++;
        tick(6);
    endtask

    task automatic test_reset_in_settle();
        int dv_cnt = 0;
        data4 = 12'h3C3;
        slow4 = 1'b1;
        tick(3);
        rst4 = 1'b1;
        tick(1);
        checks++;
        if ({sd4, dv4, ov4, cc4} !== 22'd0)
            $display("FAIL settle_reset_outputs: got sd=%h dv=%b ov=%b cc=%0d expected all zero", sd4, dv4, ov4, cc4);
        else passes++;
        rst4 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (dv4) dv_cnt++;
        end
        checks++;
        if (dv_cnt !== 0 || sd4 !== 12'h000) $display("FAIL settle_reset_abandon: got pulses=%0d sd=%h expected 0 000", dv_cnt, sd4);
        else passes++;
        slow4 = 1'b0;
        tick(4);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_high_at_reset();
        test_data_change();
        test_settle_toggle();
        test_overrun();
        test_reset_in_settle();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/slow_to_fast_capture.md
# slow_to_fast_capture

Single-clock receive-side capture for data launched in a slower domain. Runs entirely on `fast_clk` and treats `slow_clk` as an asynchronous sampled signal, not as a clock. Detects each slow rising edge through a synchronizer chain, waits for the `S`-bit bus to hold stable, then registers it into `sync_data` with a one-cycle valid strobe. It is the slow-to-fast counterpart of the existing fast-to-slow synchronizer path.

## Interface
- `S`, 12: data bus width.
- `SYNC_STAGES`, 2: flops in the `slow_clk` synchronizer chain; legal range ≥2.
- `SETTLE_CYC`, 1: number of consecutive equal-sample compares required before capture; legal range ≥1.
- `fast_clk`  in  1: sole clock, rising-edge.
- `reset`  in  1: synchronous, active-high.
- `slow_clk`  in  1: asynchronous level from the slow domain; sampled as data only.
- `async_data`  in  S: bus launched on slow rising edges.
- `sync_data`  out  S: last captured word, held until the next capture.
- `data_valid`  out  1: one-cycle pulse, high in the cycle `sync_data` first shows a new word.
- `overrun`  out  1: one-cycle pulse when a new slow edge arrives before the previous capture completes.
- `capture_count`  out  8: number of captures since reset; wraps.

## Operation
- Synchronizer: `slow_clk` passes through `SYNC_STAGES` flops to give `slow_sync`. `slow_prev` registers `slow_sync`. `rise = slow_sync & ~slow_prev & armed`.
- `armed` is cleared by reset and set on the first cycle `slow_sync==0`. This blocks a false edge when `slow_clk` is already high at reset release.
- State `IDLE`: on `rise`, go to `SETTLE`, set `cnt<=SETTLE_CYC` and `shadow<=async_data`.
- State `SETTLE`, evaluated in priority order each cycle:
  - `rise`: pulse `overrun`, set `cnt<=SETTLE_CYC` and `shadow<=async_data`, stay in `SETTLE`.
  - `async_data!=shadow`: set `shadow<=async_data` and `cnt<=SETTLE_CYC`, stay in `SETTLE`.
  - `cnt==1`: set `sync_data<=shadow`, `data_valid<=1`, `capture_count<=capture_count+1`, go to `IDLE`.
  - Otherwise: `cnt<=cnt-1`.
- `capture_count` is 8-bit modulo; 255+1 gives 0.
- `cnt` width is `$clog2(SETTLE_CYC+1)`.
- `data_valid` and `overrun` are registered. They are never high in two consecutive cycles from the same event.
- A bus that never stabilises keeps the block in `SETTLE` indefinitely. No timeout.

## Timing
- Reset values: `sync_data=0`, `data_valid=0`, `overrun=0`, `capture_count=0`, state `IDLE`, synchronizer chain 0, `slow_prev=0`, `armed=0`, `shadow=0`, `cnt=0`.
- Reset asserted mid-`SETTLE` abandons the word. No `data_valid` is produced for it.
- Let `t0` be the first `fast_clk` edge that samples `slow_clk` high, with the unit armed and the bus stable.
- `rise` is true after edge `t0+SYNC_STAGES-1`.
- `SETTLE` is entered at edge `t0+SYNC_STAGES`.
- `sync_data` and `data_valid` update at edge `t0+SYNC_STAGES+SETTLE_CYC`.
- Defaults: capture 3 edges after `t0`.
- Each bus change during `SETTLE` adds `SETTLE_CYC` cycles, counted from the change.
- Requirement on the slow side: the bus is stable for at least `SYNC_STAGES+SETTLE_CYC+1` fast cycles after each slow rising edge.
- Minimum slow high and low times: 2 fast cycles each, so both levels pass the synchronizer.
- `slow_clk` falling edges are ignored. Glitches shorter than one fast period may be missed; this is acceptable.

## Test plan
- Reset release with `slow_clk=0`, slow period 20 (fast period 10), `async_data=12'hA5C` set at slow rise → `sync_data=12'hA5C` with a single `data_valid` pulse 3 fast edges after first sampling; `capture_count=1`.
- Reset release with `slow_clk` already high → no `data_valid` until a full low→high transition; then a normal capture.
- Defaults, `async_data` changes `12'h123`→`12'h456` one cycle into `SETTLE` → exactly one capture, value `12'h456`, latency extended by 1 cycle; no capture of `12'h123`.
- `SETTLE_CYC=3`, bus toggling every fast cycle for 6 cycles then held at `12'hFFF` → one capture of `12'hFFF` 3 cycles after the last change.
- 256 slow edges with random data → every word captured in order, and `capture_count` wraps to 0 after the 256th capture.
- Force a second `slow_clk` rise while in `SETTLE` (`SETTLE_CYC=4`, short slow period) → one-cycle `overrun` pulse, the pending word is dropped, and the newer word is captured.
- Reset asserted in `SETTLE` → outputs return to zero the next cycle and no `data_valid` is produced.
